fetch_predictor: RTL and testbench

PC generation and dynamic branch prediction for the fetch stage. Drives the fetch-side PC/prediction fields of `if_stage_if` (`pc`, `branch`, `branch_addr`). Consumes the resolved-branch fields of `branch_info_if` (`pc`, `taken`, `branch_addr`, `branch_flag`) and the `predict_miss` flag that instruction decode produces. Holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and applies redirect priority for exceptions, mispredictions and stalls.

---
 rtl/fetch_predictor.sv | 174 +++++++++++++++++
 tb/tb_fetch_predictor.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_predictor.sv
// ---------------------------------------------------------------------------
// fetch_predictor
//
// Generates the fetch-stage PC and a dynamic branch prediction for it.
// The prediction comes from a direct-mapped branch target buffer (BTB) whose
// entries hold a valid bit, a tag, a target address and a 2-bit saturating
// counter. Resolved branches reported by decode train the BTB. A small
// priority mux picks the next PC from the exception, stall, mispredict and
// predicted paths.
//
// Parameters
//   ENTRIES         number of BTB entries (power of two, 4..64)
//   RESET_PC        PC loaded while reset is asserted
//
// Ports
//   clk             clock
//   rst_n           synchronous active-low reset
//   stall           hold the PC; also blocks BTB training and mispredict redirect
//   excp_redirect   exception/ertn redirect request (beats stall)
//   excp_pc         exception/ertn target
//   bi_flag         decode holds a branch/jump whose outcome is in bi_*
//   bi_pc           PC of the resolved branch
//   bi_taken        resolved direction
//   bi_target       resolved target
//   predict_miss    decode detected a misprediction
//   if_valid        fetch PC valid (0 during reset)
//   if_pc           current fetch PC
//   if_pred_taken   BTB predicts the branch at if_pc is taken
//   if_pred_target  predicted next fetch PC
// ---------------------------------------------------------------------------
module fetch_predictor #(
  parameter int          ENTRIES  = 16,
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        excp_redirect,
  input  logic [31:0] excp_pc,
  input  logic        bi_flag,
  input  logic [31:0] bi_pc,
  input  logic        bi_taken,
  input  logic [31:0] bi_target,
  input  logic        predict_miss,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_target
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDX;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [31:0]     pc_q;
  logic [31:0]     pc_d;
  logic            valid_q;

  logic            btb_valid_q  [ENTRIES];
  logic [TAGW-1:0] btb_tag_q    [ENTRIES];
  logic [31:0]     btb_target_q [ENTRIES];
  logic [1:0]      btb_ctr_q    [ENTRIES];

  // -------------------------------------------------------------------------
  // Lookup on the current fetch PC (purely combinational; a write in this
  // cycle is not bypassed, so the prediction reflects the old contents)
  // -------------------------------------------------------------------------
  logic [IDX-1:0]  look_idx;
  logic [TAGW-1:0] look_tag;
  logic            look_hit;
  logic [31:0]     pc_plus4;

  assign look_idx = pc_q[IDX+1:2];
  assign look_tag = pc_q[31:IDX+2];
  assign look_hit = btb_valid_q[look_idx] && (btb_tag_q[look_idx] == look_tag);
  assign pc_plus4 = pc_q + 32'd4;   // wraps modulo 2^32

  assign if_pred_taken  = look_hit && btb_ctr_q[look_idx][1];
  assign if_pred_target = if_pred_taken ? btb_target_q[look_idx] : pc_plus4;

  assign if_pc    = pc_q;
  assign if_valid = valid_q;

  // -------------------------------------------------------------------------
  // Training path for the branch resolved in decode
  // -------------------------------------------------------------------------
  logic [IDX-1:0]  upd_idx;
  logic [TAGW-1:0] upd_tag;
  logic            upd_hit;
  logic            upd_en;
  logic            upd_wr;
  logic [1:0]      upd_ctr_old;
  logic [1:0]      upd_ctr_d;

  assign upd_idx     = bi_pc[IDX+1:2];
  assign upd_tag     = bi_pc[31:IDX+2];
  assign upd_hit     = btb_valid_q[upd_idx] && (btb_tag_q[upd_idx] == upd_tag);
  assign upd_ctr_old = btb_ctr_q[upd_idx];

  // Training is independent of predict_miss: every resolved branch counts,
  // but a held (stalled) or squashed (exception) instruction must not be
  // counted, otherwise it would be counted again when re-presented.
  assign upd_en = rst_n && bi_flag && !stall && !excp_redirect;

  // A not-taken branch that misses is not worth an entry.
  assign upd_wr = upd_en && (upd_hit || bi_taken);

  always_comb begin
    upd_ctr_d = upd_ctr_old;
    if (!upd_hit) begin
      upd_ctr_d = 2'b10;                 // fresh allocation: weakly taken
    end else if (bi_taken) begin
      if (upd_ctr_old != 2'b11) upd_ctr_d = upd_ctr_old + 2'd1;
    end else begin
      if (upd_ctr_old != 2'b00) upd_ctr_d = upd_ctr_old - 2'd1;
    end
  end

  // -------------------------------------------------------------------------
  // BTB storage, one slice per entry. Only the valid bits are reset, which
  // empties the buffer in a single cycle; tag/target/ctr are don't-care
  // while their valid bit is clear.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_btb
    logic sel;
    assign sel = upd_wr && (upd_idx == IDX'(gi));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        btb_valid_q[gi] <= 1'b0;
      end else if (sel) begin
        btb_valid_q[gi] <= 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (sel) begin
        btb_tag_q[gi] <= upd_tag;
        btb_ctr_q[gi] <= upd_ctr_d;
        // A not-taken hit keeps the previously learned target.
        if (bi_taken) begin
          btb_target_q[gi] <= bi_target;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-PC selection: exception > stall > mispredict > prediction
  // -------------------------------------------------------------------------
  always_comb begin
    pc_d = if_pred_target;
    if (excp_redirect) begin
      pc_d = excp_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (predict_miss) begin
      pc_d = bi_taken ? bi_target : (bi_pc + 32'd4);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_predictor.sv
// ---------------------------------------------------------------------------
// tb_fetch_predictor
//
// Directed test of fetch_predictor (ENTRIES = 16, RESET_PC = 1c00_0000).
// Inputs change and outputs are sampled 1 ns after the rising edge.
// Internal BTB counters are observed through the prediction they produce.
// ---------------------------------------------------------------------------
module tb_fetch_predictor;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        excp_redirect;
  logic [31:0] excp_pc;
  logic        bi_flag;
  logic [31:0] bi_pc;
  logic        bi_taken;
  logic [31:0] bi_target;
  logic        predict_miss;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;

  int n_cmp;
  int n_err;

  fetch_predictor #(
    .ENTRIES  (16),
    .RESET_PC (32'h1c00_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .excp_redirect  (excp_redirect),
    .excp_pc        (excp_pc),
    .bi_flag        (bi_flag),
    .bi_pc          (bi_pc),
    .bi_taken       (bi_taken),
    .bi_target      (bi_target),
    .predict_miss   (predict_miss),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .if_pred_target (if_pred_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  task automatic clear_inputs();
    stall         = 1'b0;
    excp_redirect = 1'b0;
    excp_pc       = 32'h0;
    bi_flag       = 1'b0;
    bi_pc         = 32'h0;
    bi_taken      = 1'b0;
    bi_target     = 32'h0;
    predict_miss  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mispredict redirect without training, landing on addr.
  task automatic goto_pc(input logic [31:0] addr);
    bi_flag      = 1'b0;
    bi_pc        = addr - 32'd4;
    bi_taken     = 1'b0;
    predict_miss = 1'b1;
    step();
    clear_inputs();
  endtask

  // Resolved branch with mispredict; trains the BTB.
  task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    bi_flag      = 1'b1;
    bi_pc        = pc;
    bi_taken     = taken;
    bi_target    = tgt;
    predict_miss = 1'b1;
    step();
    clear_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_inputs();
    rst_n = 1'b0;
    #1;
    step();
    step();

    // Reset state
    check_eq("rst_valid",   {31'h0, if_valid},      32'h0);
    check_eq("rst_pc",      if_pc,                  32'h1c00_0000);
    check_eq("rst_ptaken",  {31'h0, if_pred_taken}, 32'h0);
    check_eq("rst_ptarget", if_pred_target,         32'h1c00_0004);

    // Sequential fetch after reset release
    rst_n = 1'b1;
    step();
    check_eq("seq1_pc",    if_pc,                  32'h1c00_0004);
    check_eq("seq1_valid", {31'h0, if_valid},      32'h1);
    check_eq("seq1_ptk",   {31'h0, if_pred_taken}, 32'h0);
    step();
    check_eq("seq2_pc",    if_pc,                  32'h1c00_0008);
    check_eq("seq2_ptk",   {31'h0, if_pred_taken}, 32'h0);

    // Taken mispredict allocates entry 4 (ctr=2)
    resolve(32'h1c00_0010, 1'b1, 32'h1c00_0100);
    check_eq("alloc_redir", if_pc, 32'h1c00_0100);
    goto_pc(32'h1c00_0010);
    check_eq("hit_ptk",  {31'h0, if_pred_taken}, 32'h1);
    check_eq("hit_ptgt", if_pred_target,         32'h1c00_0100);
    step();
    check_eq("hit_follow", if_pc, 32'h1c00_0100);

    // Not-taken twice: ctr 2->1->0
    resolve(32'h1c00_0010, 1'b0, 32'h0);
    check_eq("nt1_redir", if_pc, 32'h1c00_0014);
    goto_pc(32'h1c00_0010);
    check_eq("nt1_ptk",  {31'h0, if_pred_taken}, 32'h0);
    check_eq("nt1_ptgt", if_pred_target,         32'h1c00_0014);
    resolve(32'h1c00_0010, 1'b0, 32'h0);
    check_eq("nt2_redir", if_pc, 32'h1c00_0014);

    // Stall with pending mispredict: hold, no update, then once on release
    stall        = 1'b1;
    bi_flag      = 1'b1;
    bi_pc        = 32'h1c00_0010;
    bi_taken     = 1'b1;
    bi_target    = 32'h1c00_0100;
    predict_miss = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("stall_hold%0d", i), if_pc, 32'h1c00_0014);
    end
    stall = 1'b0;
    step();
    clear_inputs();
    check_eq("stall_release", if_pc, 32'h1c00_0100);
    // ctr should be 1 now (0 + exactly one increment): still not taken
    goto_pc(32'h1c00_0010);
    check_eq("stall_ctr1_ptk", {31'h0, if_pred_taken}, 32'h0);
    // one more taken with a new target: ctr 1->2, predicts taken
    resolve(32'h1c00_0010, 1'b1, 32'h1c00_0200);
    check_eq("retrain_redir", if_pc, 32'h1c00_0200);
    goto_pc(32'h1c00_0010);
    check_eq("retrain_ptk",  {31'h0, if_pred_taken}, 32'h1);
    check_eq("retrain_ptgt", if_pred_target,         32'h1c00_0200);

    // Exception with stall and mispredict: exception wins, no BTB update
    excp_redirect = 1'b1;
    excp_pc       = 32'h1c00_8000;
    stall         = 1'b1;
    bi_flag       = 1'b1;
    bi_pc         = 32'h1c00_0020;
    bi_taken      = 1'b1;
    bi_target     = 32'h1c00_0300;
    predict_miss  = 1'b1;
    step();
    check_eq("excp_stall_pc", if_pc, 32'h1c00_8000);
    stall   = 1'b0;
    excp_pc = 32'h1c00_9000;
    step();
    clear_inputs();
    check_eq("excp_pc", if_pc, 32'h1c00_9000);
    goto_pc(32'h1c00_0020);
    check_eq("excp_no_upd", {31'h0, if_pred_taken}, 32'h0);

    // Aliasing: 1c00_0050 shares index 4 with 1c00_0010
    resolve(32'h1c00_0050, 1'b1, 32'h1c00_0400);
    check_eq("alias_redir", if_pc, 32'h1c00_0400);
    goto_pc(32'h1c00_0010);
    check_eq("alias_old_ptk",  {31'h0, if_pred_taken}, 32'h0);
    check_eq("alias_old_ptgt", if_pred_target,         32'h1c00_0014);
    goto_pc(32'h1c00_0050);
    check_eq("alias_new_ptk",  {31'h0, if_pred_taken}, 32'h1);
    check_eq("alias_new_ptgt", if_pred_target,         32'h1c00_0400);

    // PC wrap at the top of the address space
    excp_redirect = 1'b1;
    excp_pc       = 32'hffff_fffc;
    step();
    clear_inputs();
    check_eq("wrap_pc",   if_pc,          32'hffff_fffc);
    check_eq("wrap_ptgt", if_pred_target, 32'h0000_0000);
    step();
    check_eq("wrap_next", if_pc,          32'h0000_0000);

    // Reset mid-operation beats every other input and empties the BTB
    rst_n         = 1'b0;
    excp_redirect = 1'b1;
    excp_pc       = 32'h1c00_7000;
    bi_flag       = 1'b1;
    bi_pc         = 32'h1c00_0030;
    bi_taken      = 1'b1;
    bi_target     = 32'h1c00_0500;
    predict_miss  = 1'b1;
    step();
    clear_inputs();
    check_eq("mrst_pc",    if_pc,             32'h1c00_0000);
    check_eq("mrst_valid", {31'h0, if_valid}, 32'h0);
    rst_n = 1'b1;
    goto_pc(32'h1c00_0050);
    check_eq("mrst_empty50", {31'h0, if_pred_taken}, 32'h0);
    goto_pc(32'h1c00_0030);
    check_eq("mrst_empty30", {31'h0, if_pred_taken}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
